// File: rtl/addr_bus_arbiter.sv
// addr_bus_arbiter: round-robin owner of the shared decoder address bus.
// One registered grant per tenure, a one-cycle dead gap between owners,
// and a hold limit whose forced release is flagged on timeout_err.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          per-requester request vector
//   req_addr     packed requester addresses, slice i at [i*ADDR_W +: ADDR_W]
//   release_req  per-requester release; only the owner's bit is honoured
//   gnt          one-hot registered grant
//   owner        index of current owner, 0 when idle
//   bus_addr     address latched at grant time, held through the gap
//   bus_valid    high while bus_addr belongs to a live owner
//   timeout_err  one-cycle pulse in the gap after a forced release

module addr_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 3,
    parameter int HOLD_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0]          release_req,
    output logic [N_REQ-1:0]          gnt,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic                      bus_valid,
    output logic                      timeout_err
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t state, state_n;

    logic [PTR_W-1:0]  rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [PTR_W-1:0]  owner_n;
    logic [ADDR_W-1:0] bus_addr_n;
    logic              bus_valid_n;
    logic              timeout_err_n;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic              own_rel;
    logic              own_req;
    logic              hold_done;

    // Unpacked view of the requester address slices.
    logic [ADDR_W-1:0] addr_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    // Round-robin search: first requester after rr_ptr, wrapping.
    // rr_ptr holds the last owner, so it gets the lowest priority.
    always_comb begin : arb
        int               idx;
        logic [PTR_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(rr_ptr) + k) % N_REQ;
            cand = PTR_W'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign own_rel   = release_req[owner];
    assign own_req   = req[owner];
    assign hold_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= PTR_RST;
            cnt         <= '0;
            gnt         <= '0;
            owner       <= '0;
            bus_addr    <= '0;
            bus_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            cnt         <= cnt_n;
            gnt         <= gnt_n;
            owner       <= owner_n;
            bus_addr    <= bus_addr_n;
            bus_valid   <= bus_valid_n;
            timeout_err <= timeout_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        cnt_n         = cnt;
        gnt_n         = gnt;
        owner_n       = owner;
        bus_addr_n    = bus_addr;
        bus_valid_n   = bus_valid;
        timeout_err_n = 1'b0;

        unique case (state)
            IDLE, GAP: begin
                gnt_n       = '0;
                owner_n     = '0;
                bus_valid_n = 1'b0;
                if (win_found) begin
                    state_n         = OWN;
                    gnt_n[win_idx]  = 1'b1;
                    owner_n         = win_idx;
                    bus_addr_n      = addr_arr[win_idx];
                    bus_valid_n     = 1'b1;
                    rr_ptr_n        = win_idx;
                    cnt_n           = '0;
                end else begin
                    state_n = IDLE;
                end
            end

            OWN: begin
                if (own_rel || !own_req || hold_done) begin
                    state_n     = GAP;
                    gnt_n       = '0;
                    owner_n     = '0;
                    bus_valid_n = 1'b0;
                    // Only a pure timeout is flagged; a release or
                    // request drop in the same cycle is voluntary.
                    timeout_err_n = !own_rel && own_req;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
